// File: rtl/spi_pkg.sv
// Shared SPI definitions: flash-style command opcodes, responder states and ID byte selection.
package spi_pkg;

    localparam logic [7:0] CMD_READ_ID   = 8'h9F;
    localparam logic [7:0] CMD_STATUS    = 8'h05;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_PROGRAM   = 8'h02;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ID,
        ST_STATUS,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } spi_state_t;

    // Byte idx of a 32-bit ID word, idx 0 being the most significant byte.
    function automatic logic [7:0] id_byte(input logic [31:0] id, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = id[31:24];
            2'd1:    b = id[23:16];
            2'd2:    b = id[15:8];
            default: b = id[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronisers for the SPI pins plus edge detection on cs and sck.
module spi_sync_edge
    import spi_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic cs,
    input  logic sck,
    input  logic mosi,
    output logic cs_s,
    output logic mosi_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall
);

    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sck_p;
    logic                   cs_p;

    // Idle-bus reset values keep a reset from looking like a frame edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q   <= '1;
            sck_q  <= '0;
            mosi_q <= '1;
            sck_p  <= 1'b0;
            cs_p   <= 1'b1;
        end else begin
            cs_q   <= {cs_q[SYNC_STAGES-2:0], cs};
            sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sck_p  <= sck_q[SYNC_STAGES-1];
            cs_p   <= cs_q[SYNC_STAGES-1];
        end
    end

    assign cs_s     = cs_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_p;
    assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_p;
    assign cs_rise  = cs_q[SYNC_STAGES-1] & ~cs_p;
    assign cs_fall  = ~cs_q[SYNC_STAGES-1] & cs_p;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder emulating a small serial flash over a byte-memory port.
module spi_responder
    import spi_pkg::*;
#(
    parameter logic [31:0] ID = 32'hEF401800,
    parameter int unsigned AW = 24
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic          cs,
    input  logic          sck,
    input  logic          mosi,
    output logic          miso,
    output logic          miso_oe,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_rdata,
    output logic          mem_wr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    status,
    output logic          frame_done
);

    logic       cs_s;
    logic       mosi_s;
    logic       sck_rise;
    logic       sck_fall;
    logic       cs_rise;
    logic       cs_fall;

    spi_state_t state;
    spi_state_t state_nx;

    logic [2:0] bit_cnt;
    logic [6:0] rx;
    logic [7:0] tx;
    logic [1:0] byte_cnt;
    logic       is_write;
    logic       rd_pend;
    logic [1:0] warm;
    logic       armed;

    logic       byte_done_c;
    logic [7:0] rx_byte_c;

    spi_sync_edge u_sync (
        .clk      (wb_clk),
        .rst_n    (wb_rst_n),
        .cs       (cs),
        .sck      (sck),
        .mosi     (mosi),
        .cs_s     (cs_s),
        .mosi_s   (mosi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall)
    );

    assign rx_byte_c   = {rx, mosi_s};
    assign byte_done_c = sck_rise && !cs_s && (state != ST_IDLE) && (bit_cnt == 3'd7);

    // A frame may only start once cs has been seen high with the synchronisers settled.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            warm  <= 2'b00;
            armed <= 1'b0;
        end else begin
            warm <= {warm[0], 1'b1};
            if (warm[1] && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (cs_rise) begin
            state_nx = ST_IDLE;
        end else if (state == ST_IDLE) begin
            if (cs_fall && armed) begin
                state_nx = ST_CMD;
            end
        end else if (byte_done_c) begin
            case (state)
                ST_CMD: begin
                    case (rx_byte_c)
                        CMD_READ_ID:   state_nx = ST_ID;
                        CMD_STATUS:    state_nx = ST_STATUS;
                        CMD_FAST_READ: state_nx = ST_ADDR;
                        CMD_PROGRAM:   state_nx = ST_ADDR;
                        default:       state_nx = ST_IGNORE;
                    endcase
                end
                ST_ADDR: begin
                    if (byte_cnt == 2'd2) begin
                        state_nx = is_write ? ST_WDATA : ST_DUMMY;
                    end
                end
                ST_DUMMY: state_nx = ST_RDATA;
                default:  state_nx = state;
            endcase
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            miso       <= 1'b1;
            miso_oe    <= 1'b0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wdata  <= 8'h00;
            frame_done <= 1'b0;
            bit_cnt    <= 3'd0;
            rx         <= 7'h7F;
            tx         <= 8'hFF;
            byte_cnt   <= 2'd0;
            is_write   <= 1'b0;
            rd_pend    <= 1'b0;
        end else begin
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            frame_done <= 1'b0;
            rd_pend    <= mem_rd;

            // Read data lands a cycle after the strobe, well before the next sck fall.
            if (rd_pend) begin
                tx <= mem_rdata;
            end
            if (mem_wr) begin
                mem_addr <= mem_addr + AW'(1);
            end

            if (cs_rise) begin
                frame_done <= (state != ST_IDLE);
                miso       <= 1'b1;
                miso_oe    <= 1'b0;
            end else if (state == ST_IDLE) begin
                if (cs_fall && armed) begin
                    bit_cnt  <= 3'd0;
                    byte_cnt <= 2'd0;
                    tx       <= 8'hFF;
                    miso_oe  <= 1'b1;
                end
            end else begin
                if (sck_rise) begin
                    rx      <= rx_byte_c[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (sck_fall) begin
                    miso <= tx[7];
                    tx   <= {tx[6:0], 1'b1};
                end
                if (byte_done_c) begin
                    case (state)
                        ST_CMD: begin
                            byte_cnt <= 2'd0;
                            case (rx_byte_c)
                                CMD_READ_ID:   tx <= id_byte(ID, 2'd0);
                                CMD_STATUS:    tx <= status;
                                CMD_FAST_READ: is_write <= 1'b0;
                                CMD_PROGRAM:   is_write <= 1'b1;
                                default:       tx <= 8'hFF;
                            endcase
                        end
                        ST_ID: begin
                            if (byte_cnt != 2'd3) begin
                                byte_cnt <= byte_cnt + 2'd1;
                                tx       <= id_byte(ID, byte_cnt + 2'd1);
                            end
                        end
                        ST_STATUS: tx <= status;
                        ST_ADDR: begin
                            mem_addr <= AW'({mem_addr, rx_byte_c});
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                        ST_DUMMY: mem_rd <= 1'b1;
                        ST_RDATA: begin
                            mem_addr <= mem_addr + AW'(1);
                            mem_rd   <= 1'b1;
                        end
                        ST_WDATA: begin
                            mem_wdata <= rx_byte_c;
                            mem_wr    <= 1'b1;
                        end
                        default: tx <= 8'hFF;
                    endcase
                end
            end
        end
    end

endmodule
